// File: rtl/spi_master_ctrl_if.sv
// Bundle of the local request/response signals and SPI pins for spi_master_ctrl.
// The controller takes the master modport; local logic (or a bench) takes the slave modport.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 32
);
  // Request handshake: start acts as valid and !busy acts as ready. A frame
  // begins on the clk edge where start=1 and busy=0. tx_data is sampled only
  // on that edge. rx_data is valid on the edge that raises done, which lasts
  // exactly one cycle. start while busy=1 is dropped, not queued.
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-slave SPI master, mode 0, MSB first; one DATA_W-bit full-duplex frame per start.
// Define SPI_MASTER_LOOPBACK_EN to feed mosi back into the receive shifter (miso ignored).
module spi_master_ctrl #(
  parameter int DATA_W   = 32,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_ctrl_if.master  bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // SETUP counts 0..CS_SETUP (the extra cycle is the accept-to-cs_n cycle),
  // HOLD counts 0..CS_HOLD-1; both share one phase counter.
  localparam int PH_MAX = (CS_SETUP + 1 > CS_HOLD) ? CS_SETUP + 1 : CS_HOLD;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP);
  localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);

  state_t              r_state;
  logic [PH_W-1:0]     r_ph_cnt;
  logic [HALF_W-1:0]   r_half_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_sclk;
  logic                r_cs_n;
  logic                r_mosi;
  logic                r_busy;
  logic                r_done;

  state_t              w_state;
  logic [PH_W-1:0]     w_ph_cnt;
  logic [HALF_W-1:0]   w_half_cnt;
  logic [BIT_W-1:0]    w_bit_cnt;
  logic [DATA_W-1:0]   w_tx;
  logic [DATA_W-1:0]   w_rx;
  logic [DATA_W-1:0]   w_rx_data;
  logic                w_sclk;
  logic                w_cs_n;
  logic                w_mosi;
  logic                w_busy;
  logic                w_done;
  logic                w_rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_rx_bit = r_mosi;
`else
  assign w_rx_bit = bus.miso;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ph_cnt   <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ph_cnt   <= w_ph_cnt;
      r_half_cnt <= w_half_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_tx       <= w_tx;
      r_rx       <= w_rx;
      r_rx_data  <= w_rx_data;
      r_sclk     <= w_sclk;
      r_cs_n     <= w_cs_n;
      r_mosi     <= w_mosi;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_ph_cnt   = r_ph_cnt;
    w_half_cnt = r_half_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_tx       = r_tx;
    w_rx       = r_rx;
    w_rx_data  = r_rx_data;
    w_sclk     = r_sclk;
    w_cs_n     = r_cs_n;
    w_mosi     = r_mosi;
    w_busy     = r_busy;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_tx     = bus.tx_data;
          w_mosi   = bus.tx_data[DATA_W-1];
          w_cs_n   = 1'b0;
          w_busy   = 1'b1;
          w_ph_cnt = '0;
          w_state  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (r_ph_cnt == SETUP_LAST) begin
          w_ph_cnt   = '0;
          w_half_cnt = '0;
          w_bit_cnt  = '0;
          w_state    = S_XFER;
        end else begin
          w_ph_cnt = r_ph_cnt + 1'b1;
        end
      end

      S_XFER: begin
        if (r_half_cnt == HALF_LAST) begin
          w_half_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
            w_rx   = {r_rx[DATA_W-2:0], w_rx_bit};
          end else begin
            // Rotate so the next bit sits at the MSB; mosi follows it.
            w_sclk = 1'b0;
            w_tx   = {r_tx[DATA_W-2:0], r_tx[DATA_W-1]};
            w_mosi = r_tx[DATA_W-2];
            if (r_bit_cnt == BIT_LAST) begin
              w_bit_cnt = '0;
              w_ph_cnt  = '0;
              w_state   = S_HOLD;
            end else begin
              w_bit_cnt = r_bit_cnt + 1'b1;
            end
          end
        end else begin
          w_half_cnt = r_half_cnt + 1'b1;
        end
      end

      S_HOLD: begin
        if (r_ph_cnt == HOLD_LAST) begin
          w_ph_cnt  = '0;
          w_cs_n    = 1'b1;
          w_mosi    = 1'b0;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_rx_data = r_rx;
          w_state   = S_IDLE;
        end else begin
          w_ph_cnt = r_ph_cnt + 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign bus.sclk    = r_sclk;
  assign bus.cs_n    = r_cs_n;
  assign bus.mosi    = r_mosi;
  assign o_dbg_state = r_state;

endmodule
